// File: rtl/dnpcie_aurora_pkg.sv
// Shared types and constants for the Aurora RX buffer / NFC generator.
package dnpcie_aurora_pkg;

    localparam logic [3:0] NFC_XOFF = 4'hF;
    localparam logic [3:0] NFC_XON  = 4'h0;

    typedef enum logic [1:0] {
        NFC_RUN      = 2'd0,
        NFC_XOFF_REQ = 2'd1,
        NFC_PAUSED   = 2'd2,
        NFC_XON_REQ  = 2'd3
    } nfc_state_t;

    typedef struct packed {
        logic [31:0] tdata;
        logic [3:0]  tkeep;
        logic        tlast;
    } rx_beat_t;

    localparam int unsigned RX_BEAT_W = $bits(rx_beat_t);

endpackage

// File: rtl/dnpcie_aurora_rx_fifo.sv
// Synchronous FWFT FIFO: RAM array feeding one output register; o_fill counts
// every beat held, including the one sitting in the output register.
module dnpcie_aurora_rx_fifo
    import dnpcie_aurora_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  rx_beat_t              i_wr_beat,
    output logic                  o_wr_accept,
    output rx_beat_t              o_rd_beat,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DEPTH_LOG2:0]   o_fill
);

    localparam int unsigned         DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    rx_beat_t              r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_mem_cnt;
    logic [DEPTH_LOG2:0]   r_fill;
    rx_beat_t              r_out;
    logic                  r_out_valid;

    logic w_rd_fire;
    logic w_wr_fire;
    logic w_load;

    // A read in the same cycle frees a slot, so a full FIFO still takes a beat.
    assign w_rd_fire = r_out_valid & i_rd_ready;
    assign w_wr_fire = i_wr_en & ((r_fill < FULL_LVL) | w_rd_fire);
    assign w_load    = (r_mem_cnt != '0) & (~r_out_valid | w_rd_fire);

    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= i_wr_beat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_fill      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + PTR_ONE;
                r_out       <= r_mem[r_rd_ptr];
                r_out_valid <= 1'b1;
            end else if (w_rd_fire) begin
                r_out_valid <= 1'b0;
            end
            case ({w_wr_fire, w_load})
                2'b10:   r_mem_cnt <= r_mem_cnt + CNT_ONE;
                2'b01:   r_mem_cnt <= r_mem_cnt - CNT_ONE;
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_fill <= r_fill + CNT_ONE;
                2'b01:   r_fill <= r_fill - CNT_ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_wr_accept = w_wr_fire;
    assign o_rd_beat   = r_out;
    assign o_rd_valid  = r_out_valid;
    assign o_fill      = r_fill;

endmodule

// File: rtl/dnpcie_aurora_rx_nfc.sv
// Aurora RX buffer with XOFF/XON native flow control toward the remote side.
// Optional saturating drop counter: define DNPCIE_AURORA_RX_OVF_COUNT_EN.
module dnpcie_aurora_rx_nfc
    import dnpcie_aurora_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned HIGH_WM    = 384,
    parameter int unsigned LOW_WM     = 128
) (
    input  logic                  user_clk,
    input  logic                  reset,
    input  logic                  channel_up,
    input  logic [31:0]           rx_tdata,
    input  logic [3:0]            rx_tkeep,
    input  logic                  rx_tvalid,
    input  logic                  rx_tlast,
    output logic                  nfc_tx_tvalid,
    output logic [3:0]            nfc_tx_tdata,
    input  logic                  nfc_tx_tready,
    output logic [31:0]           m_axis_tdata,
    output logic [3:0]            m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  paused,
    output logic                  overflow
`ifdef DNPCIE_AURORA_RX_OVF_COUNT_EN
    ,
    output logic [15:0]           ovf_count
`endif
);

    localparam logic [DEPTH_LOG2:0] HIGH_LVL = (DEPTH_LOG2 + 1)'(HIGH_WM);
    localparam logic [DEPTH_LOG2:0] LOW_LVL  = (DEPTH_LOG2 + 1)'(LOW_WM);

    rx_beat_t            w_wr_beat;
    rx_beat_t            w_rd_beat;
    logic                w_wr_accept;
    logic                w_drop;
    logic [DEPTH_LOG2:0] w_fill;

    nfc_state_t r_state;
    logic       r_nfc_tvalid;
    logic [3:0] r_nfc_tdata;
    logic       r_paused;
    logic       r_overflow;

    assign w_wr_beat = '{tdata: rx_tdata, tkeep: rx_tkeep, tlast: rx_tlast};

    dnpcie_aurora_rx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk       (user_clk),
        .i_rst       (reset),
        .i_wr_en     (rx_tvalid),
        .i_wr_beat   (w_wr_beat),
        .o_wr_accept (w_wr_accept),
        .o_rd_beat   (w_rd_beat),
        .o_rd_valid  (m_axis_tvalid),
        .i_rd_ready  (m_axis_tready),
        .o_fill      (w_fill)
    );

    assign m_axis_tdata = w_rd_beat.tdata;
    assign m_axis_tkeep = w_rd_beat.tkeep;
    assign m_axis_tlast = w_rd_beat.tlast;
    assign fill         = w_fill;

    assign w_drop = rx_tvalid & ~w_wr_accept;

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
        end
    end

    assign overflow = r_overflow;

`ifdef DNPCIE_AURORA_RX_OVF_COUNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

    // Losing the channel abandons any pending request; the buffer is left intact.
    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_state      <= NFC_RUN;
            r_nfc_tvalid <= 1'b0;
            r_nfc_tdata  <= NFC_XON;
            r_paused     <= 1'b0;
        end else if (!channel_up) begin
            r_state      <= NFC_RUN;
            r_nfc_tvalid <= 1'b0;
            r_paused     <= 1'b0;
        end else begin
            case (r_state)
                NFC_RUN: begin
                    if (w_fill >= HIGH_LVL) begin
                        r_state      <= NFC_XOFF_REQ;
                        r_nfc_tvalid <= 1'b1;
                        r_nfc_tdata  <= NFC_XOFF;
                    end
                end
                NFC_XOFF_REQ: begin
                    if (nfc_tx_tready) begin
                        r_state      <= NFC_PAUSED;
                        r_nfc_tvalid <= 1'b0;
                        r_paused     <= 1'b1;
                    end
                end
                NFC_PAUSED: begin
                    if (w_fill <= LOW_LVL) begin
                        r_state      <= NFC_XON_REQ;
                        r_nfc_tvalid <= 1'b1;
                        r_nfc_tdata  <= NFC_XON;
                    end
                end
                NFC_XON_REQ: begin
                    if (nfc_tx_tready) begin
                        r_state      <= NFC_RUN;
                        r_nfc_tvalid <= 1'b0;
                        r_paused     <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= NFC_RUN;
                    r_nfc_tvalid <= 1'b0;
                    r_paused     <= 1'b0;
                end
            endcase
        end
    end

    assign nfc_tx_tvalid = r_nfc_tvalid;
    assign nfc_tx_tdata  = r_nfc_tdata;
    assign paused        = r_paused;

endmodule

// File: tb/tb_dnpcie_aurora_rx_nfc.sv
// Scoreboard bench for dnpcie_aurora_rx_nfc: stimulus queues expected beats,
// a negedge monitor pops and compares on every output handshake.
module tb_dnpcie_aurora_rx_nfc;
    import dnpcie_aurora_pkg::*;

    localparam int unsigned DL2 = 9;

    logic        user_clk = 1'b0;
    logic        reset;
    logic        channel_up;
    logic [31:0] rx_tdata;
    logic [3:0]  rx_tkeep;
    logic        rx_tvalid;
    logic        rx_tlast;
    logic        nfc_tx_tvalid;
    logic [3:0]  nfc_tx_tdata;
    logic        nfc_tx_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [DL2:0] fill;
    logic        paused;
    logic        overflow;
`ifdef DNPCIE_AURORA_RX_OVF_COUNT_EN
    logic [15:0] ovf_count;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned ovf_pulses = 0;
    int unsigned seq = 0;
    rx_beat_t    exp_q[$];

    always #5 user_clk = ~user_clk;

    dnpcie_aurora_rx_nfc #(
        .DEPTH_LOG2 (DL2),
        .HIGH_WM    (384),
        .LOW_WM     (128)
    ) dut (
        .user_clk      (user_clk),
        .reset         (reset),
        .channel_up    (channel_up),
        .rx_tdata      (rx_tdata),
        .rx_tkeep      (rx_tkeep),
        .rx_tvalid     (rx_tvalid),
        .rx_tlast      (rx_tlast),
        .nfc_tx_tvalid (nfc_tx_tvalid),
        .nfc_tx_tdata  (nfc_tx_tdata),
        .nfc_tx_tready (nfc_tx_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fill          (fill),
        .paused        (paused),
        .overflow      (overflow)
`ifdef DNPCIE_AURORA_RX_OVF_COUNT_EN
        ,
        .ovf_count     (ovf_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rx_beat_t mk(input int unsigned s);
        rx_beat_t    b;
        logic [31:0] v;
        v       = s;
        b.tdata = (v * 32'h9E3779B1) ^ 32'h5A5A0000;
        case (v[1:0])
            2'd0:    b.tkeep = 4'hF;
            2'd1:    b.tkeep = 4'h1;
            2'd2:    b.tkeep = 4'h3;
            default: b.tkeep = 4'h7;
        endcase
        b.tlast = ((s % 5) == 4);
        return b;
    endfunction

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic drive(input bit push);
        rx_beat_t b;
        b = mk(seq);
        seq++;
        rx_tvalid = 1'b1;
        rx_tdata  = b.tdata;
        rx_tkeep  = b.tkeep;
        rx_tlast  = b.tlast;
        if (push) exp_q.push_back(b);
    endtask

    task automatic idle();
        rx_tvalid = 1'b0;
    endtask

    task automatic wait_fill(input int unsigned target, input string name);
        int unsigned n;
        n = 0;
        while ((fill != target[DL2:0]) && (n < 2000)) begin
            tick();
            n++;
        end
        check(name, fill, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fill"}, fill, 0);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_payload"}, {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, 0);
        check({tag, "_nfc_tvalid"}, nfc_tx_tvalid, 0);
        check({tag, "_nfc_tdata"}, nfc_tx_tdata, 0);
        check({tag, "_paused"}, paused, 0);
        check({tag, "_overflow"}, overflow, 0);
`ifdef DNPCIE_AURORA_RX_OVF_COUNT_EN
        check({tag, "_ovf_count"}, ovf_count, 0);
`endif
    endtask

    always @(negedge user_clk) begin
        rx_beat_t e;
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got beat %0h expected none", m_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                check("stream_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, e);
            end
        end
        if (!reset && overflow) ovf_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        channel_up    = 1'b0;
        rx_tvalid     = 1'b0;
        rx_tdata      = '0;
        rx_tkeep      = '0;
        rx_tlast      = 1'b0;
        nfc_tx_tready = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset      = 1'b0;
        channel_up = 1'b1;
        tick();

        // Backpressure: fill to the high watermark, watch XOFF
        for (int i = 0; i < 384; i++) begin
            tick();
            drive(1'b1);
            if (i == 1) check("latency_n1", m_axis_tvalid, 0);
            if (i == 2) check("latency_n2", m_axis_tvalid, 1);
        end
        tick();
        idle();
        check("fill_at_high", fill, 384);
        check("nfc_not_yet", nfc_tx_tvalid, 0);
        tick();
        check("xoff_valid", nfc_tx_tvalid, 1);
        check("xoff_data", nfc_tx_tdata, 4'hF);
        check("xoff_paused", paused, 0);
        tick();
        tick();
        check("xoff_hold_valid", nfc_tx_tvalid, 1);
        check("xoff_hold_data", nfc_tx_tdata, 4'hF);
        nfc_tx_tready = 1'b1;
        tick();
        nfc_tx_tready = 1'b0;
        check("xoff_done_valid", nfc_tx_tvalid, 0);
        check("paused_set", paused, 1);

        // Drain: XON at the low watermark
        m_axis_tready = 1'b1;
        wait_fill(128, "fill_reach_low");
        check("xon_not_yet", nfc_tx_tvalid, 0);
        check("xon_pre_paused", paused, 1);
        tick();
        check("xon_valid", nfc_tx_tvalid, 1);
        check("xon_data", nfc_tx_tdata, 4'h0);
        check("xon_paused", paused, 1);
        nfc_tx_tready = 1'b1;
        tick();
        nfc_tx_tready = 1'b0;
        check("xon_done_valid", nfc_tx_tvalid, 0);
        check("paused_clear", paused, 0);
        wait_fill(0, "drain_empty");
        tick();
        tick();
        check("queue_empty_1", exp_q.size(), 0);

        // Overflow: 520 beats into a 512 deep buffer
        m_axis_tready = 1'b0;
        nfc_tx_tready = 1'b1;
        ovf_pulses    = 0;
        for (int i = 0; i < 520; i++) begin
            tick();
            drive(i < 512);
        end
        tick();
        idle();
        tick();
        tick();
        check("ovf_fill", fill, 512);
        check("ovf_pulses", ovf_pulses, 8);
        check("ovf_paused", paused, 1);
`ifdef DNPCIE_AURORA_RX_OVF_COUNT_EN
        check("ovf_count", ovf_count, 8);
`endif

        // Simultaneous write and read while full
        for (int j = 0; j < 10; j++) begin
            drive(1'b1);
            m_axis_tready = 1'b1;
            tick();
            check("full_rw_fill", fill, 512);
        end
        idle();
        m_axis_tready = 1'b0;
        tick();
        check("full_rw_fill_end", fill, 512);
        check("full_rw_no_ovf", ovf_pulses, 8);
        m_axis_tready = 1'b1;
        wait_fill(0, "drain_empty_2");
        tick();
        tick();
        check("queue_empty_2", exp_q.size(), 0);
        check("paused_after_drain", paused, 0);

        // Channel drop during a pending XOFF
        m_axis_tready = 1'b0;
        nfc_tx_tready = 1'b0;
        for (int i = 0; i < 384; i++) begin
            tick();
            drive(1'b1);
        end
        tick();
        idle();
        tick();
        check("xoff2_valid", nfc_tx_tvalid, 1);
        check("xoff2_data", nfc_tx_tdata, 4'hF);
        channel_up = 1'b0;
        tick();
        check("drop_valid", nfc_tx_tvalid, 0);
        check("drop_paused", paused, 0);
        check("drop_fill_kept", fill, 384);
        tick();
        check("drop_valid_held", nfc_tx_tvalid, 0);
        channel_up = 1'b1;
        tick();
        check("rerequest_valid", nfc_tx_tvalid, 1);

        // Reset mid-packet at fill 200
        m_axis_tready = 1'b1;
        wait_fill(200, "fill_reach_200");
        m_axis_tready = 1'b0;
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        exp_q.delete();
        reset = 1'b0;
        tick();

        // Short stream after reset
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b1);
        end
        tick();
        idle();
        repeat (5) tick();
        check("post_fill", fill, 0);
        check("queue_empty_3", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
